// File: rtl/mp3_mem_arbiter.sv
// ============================================================================
// mp3_mem_arbiter
// ----------------------------------------------------------------------------
// Two-to-one arbiter that shares one single-ported memory between the
// instruction-fetch port (read-only) and the data port (read/write with a
// byte mask). Every side uses the core's level-request / one-cycle-resp
// handshake.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   i_read, i_address     instruction read request and address
//   i_resp, i_rdata       instruction completion pulse and read data
//   d_read, d_write       data read and write requests
//   d_wmask, d_address,
//   d_wdata               data byte enables, address and write data
//   d_resp, d_rdata       data completion pulse and read data
//   mem_read, mem_write   memory strobes
//   mem_wmask,
//   mem_address,
//   mem_wdata             memory byte enables, address and write data
//   mem_resp, mem_rdata   memory completion and read data
//   busy                  high whenever a transaction is in flight
//
// Build option
//   MP3_ARB_ROUND_ROBIN_EN  when defined, simultaneous requests alternate
//                           between ports using a last-grant register.
//                           When undefined, the data port always wins ties.
// ============================================================================
module mp3_mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int MASK_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic              i_resp,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [MASK_W-1:0] d_wmask,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_resp,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [MASK_W-1:0] mem_wmask,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_resp,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [MASK_W-1:0] wmask_q, wmask_d;
    logic              write_q, write_d;

    logic d_req;
    logic grant_d;     // 1: data port wins the current arbitration
    logic serving;

    assign d_req = d_read | d_write;

`ifdef MP3_ARB_ROUND_ROBIN_EN
    // 1 = data port was granted last; reset value favours data on the first tie.
    logic last_d_q, last_d_d;

    always_comb begin
        if (d_req && i_read) begin
            grant_d = ~last_d_q;
        end else begin
            grant_d = d_req;
        end
    end
`else
    always_comb begin
        grant_d = d_req;
    end
`endif

    // ------------------------------------------------------------------
    // State and capture registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            wmask_q  <= '0;
            write_q  <= 1'b0;
`ifdef MP3_ARB_ROUND_ROBIN_EN
            last_d_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wmask_q  <= wmask_d;
            write_q  <= write_d;
`ifdef MP3_ARB_ROUND_ROBIN_EN
            last_d_q <= last_d_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next state and capture. Requester inputs are sampled only in IDLE,
    // so changes during service have no effect until the next grant.
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wmask_d  = wmask_q;
        write_d  = write_q;
`ifdef MP3_ARB_ROUND_ROBIN_EN
        last_d_d = last_d_q;
`endif
        case (state_q)
            IDLE: begin
                if (d_req || i_read) begin
                    state_d = grant_d ? SERVE_D : SERVE_I;
                    addr_d  = grant_d ? d_address : i_address;
                    wdata_d = grant_d ? d_wdata : '0;
                    wmask_d = grant_d ? d_wmask : '0;
                    // Read and write together is treated as a write.
                    write_d = grant_d & d_write;
`ifdef MP3_ARB_ROUND_ROBIN_EN
                    last_d_d = grant_d;
`endif
                end
            end
            SERVE_I, SERVE_D: begin
                if (mem_resp) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs. Strobes come only from captured registers; completion is
    // a combinational pass-through of mem_resp to the served port.
    // ------------------------------------------------------------------
    always_comb begin
        serving   = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        i_resp    = 1'b0;
        d_resp    = 1'b0;
        case (state_q)
            SERVE_I: begin
                serving  = 1'b1;
                mem_read = 1'b1;
                i_resp   = mem_resp;
            end
            SERVE_D: begin
                serving   = 1'b1;
                mem_read  = ~write_q;
                mem_write = write_q;
                d_resp    = mem_resp;
            end
            default: ;
        endcase
    end

    // Byte enables are only meaningful on writes; reads present an all-zero mask.
    generate
        for (genvar gi = 0; gi < MASK_W; gi++) begin : g_wmask
            assign mem_wmask[gi] = wmask_q[gi] & mem_write;
        end
    endgenerate

    assign mem_address = serving ? addr_q  : '0;
    assign mem_wdata   = serving ? wdata_q : '0;
    assign busy        = serving;
    assign i_rdata     = mem_rdata;
    assign d_rdata     = mem_rdata;

endmodule

// File: tb/tb_mp3_mem_arbiter.sv
// Testbench for mp3_mem_arbiter: a cycle-by-cycle vector table covering
// fetch, masked write, read, illegal read+write and spurious mem_resp,
// followed by hand-written tie, input-stability and mid-transaction reset
// sequences.
module tb_mp3_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_read;
    logic [15:0] i_address;
    logic        i_resp;
    logic [15:0] i_rdata;
    logic        d_read, d_write;
    logic [1:0]  d_wmask;
    logic [15:0] d_address, d_wdata;
    logic        d_resp;
    logic [15:0] d_rdata;
    logic        mem_read, mem_write;
    logic [1:0]  mem_wmask;
    logic [15:0] mem_address, mem_wdata;
    logic        mem_resp;
    logic [15:0] mem_rdata;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mp3_mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read), .i_address(i_address), .i_resp(i_resp), .i_rdata(i_rdata),
        .d_read(d_read), .d_write(d_write), .d_wmask(d_wmask), .d_address(d_address),
        .d_wdata(d_wdata), .d_resp(d_resp), .d_rdata(d_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_wmask(mem_wmask),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata), .busy(busy)
    );

    typedef struct packed {
        logic        i_read;
        logic [15:0] i_addr;
        logic        d_read;
        logic        d_write;
        logic [1:0]  d_wmask;
        logic [15:0] d_addr;
        logic [15:0] d_wdata;
        logic        mem_resp;
        logic [15:0] mem_rdata;
        logic        e_i_resp;
        logic        e_d_resp;
        logic        e_mem_read;
        logic        e_mem_write;
        logic [1:0]  e_wmask;
        logic [15:0] e_addr;
        logic [15:0] e_wdata;
        logic        e_busy;
    } vec_t;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_idle();
        i_read = 0; i_address = '0; d_read = 0; d_write = 0; d_wmask = '0;
        d_address = '0; d_wdata = '0; mem_resp = 0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive_idle();
        repeat (2) @(negedge clk);
        #1;
        check("rst_busy", {15'd0, busy}, 16'd0);
        check("rst_mem_read", {15'd0, mem_read}, 16'd0);
        check("rst_mem_write", {15'd0, mem_write}, 16'd0);
        check("rst_addr", mem_address, 16'd0);
        check("rst_wdata", mem_wdata, 16'd0);
        check("rst_wmask", {14'd0, mem_wmask}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Inputs are applied just after the falling edge and outputs are
    // sampled 1ns later, well away from the rising edge.
    task automatic apply_vec(input int idx, input vec_t v);
        @(negedge clk);
        i_read = v.i_read; i_address = v.i_addr;
        d_read = v.d_read; d_write = v.d_write; d_wmask = v.d_wmask;
        d_address = v.d_addr; d_wdata = v.d_wdata;
        mem_resp = v.mem_resp; mem_rdata = v.mem_rdata;
        #1;
        check($sformatf("v%0d_i_resp", idx), {15'd0, i_resp}, {15'd0, v.e_i_resp});
        check($sformatf("v%0d_d_resp", idx), {15'd0, d_resp}, {15'd0, v.e_d_resp});
        check($sformatf("v%0d_mem_read", idx), {15'd0, mem_read}, {15'd0, v.e_mem_read});
        check($sformatf("v%0d_mem_write", idx), {15'd0, mem_write}, {15'd0, v.e_mem_write});
        check($sformatf("v%0d_wmask", idx), {14'd0, mem_wmask}, {14'd0, v.e_wmask});
        check($sformatf("v%0d_addr", idx), mem_address, v.e_addr);
        check($sformatf("v%0d_wdata", idx), mem_wdata, v.e_wdata);
        check($sformatf("v%0d_busy", idx), {15'd0, busy}, {15'd0, v.e_busy});
        if (v.e_i_resp) check($sformatf("v%0d_i_rdata", idx), i_rdata, v.mem_rdata);
        if (v.e_d_resp) check($sformatf("v%0d_d_rdata", idx), d_rdata, v.mem_rdata);
        $display("vec %0d: busy=%0b rd=%0b wr=%0b addr=%04h wdata=%04h mask=%02b i_resp=%0b d_resp=%0b",
                 idx, busy, mem_read, mem_write, mem_address, mem_wdata, mem_wmask, i_resp, d_resp);
    endtask

    vec_t vecs[14];

    initial begin
        // {i_read, i_addr, d_read, d_write, d_wmask, d_addr, d_wdata, mem_resp, mem_rdata,
        //  e_i_resp, e_d_resp, e_mem_read, e_mem_write, e_wmask, e_addr, e_wdata, e_busy}
        // Single fetch at 0x0040, memory answers 0x1234 in the third SERVE cycle.
        vecs[0]  = '{1'b1, 16'h0040, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0, 16'h0000,
                     1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0};
        vecs[1]  = '{1'b1, 16'h0040, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0, 16'h0000,
                     1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 16'h0040, 16'h0000, 1'b1};
        vecs[2]  = '{1'b1, 16'h0040, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0, 16'h0000,
                     1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 16'h0040, 16'h0000, 1'b1};
        vecs[3]  = '{1'b1, 16'h0040, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b1, 16'h1234,
                     1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 16'h0040, 16'h0000, 1'b1};
        vecs[4]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0, 16'h0000,
                     1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0};
        // Masked write 0xBEEF to 0x0100, mask 01, zero-wait memory.
        vecs[5]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 2'b01, 16'h0100, 16'hBEEF, 1'b0, 16'h0000,
                     1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0};
        vecs[6]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 2'b01, 16'h0100, 16'hBEEF, 1'b1, 16'h0000,
                     1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 16'h0100, 16'hBEEF, 1'b1};
        vecs[7]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0, 16'h0000,
                     1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0};
        // Spurious mem_resp while IDLE.
        vecs[8]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b1, 16'h5555,
                     1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0};
        // Data read: mask presented on the memory side must be zero.
        vecs[9]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 2'b11, 16'h0222, 16'h7777, 1'b0, 16'h0000,
                     1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0};
        vecs[10] = '{1'b0, 16'h0000, 1'b1, 1'b0, 2'b11, 16'h0222, 16'h7777, 1'b1, 16'hA5A5,
                     1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 16'h0222, 16'h7777, 1'b1};
        // Illegal read+write: performed as a write.
        vecs[11] = '{1'b0, 16'h0000, 1'b1, 1'b1, 2'b10, 16'h0300, 16'h1111, 1'b0, 16'h0000,
                     1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0};
        vecs[12] = '{1'b0, 16'h0000, 1'b1, 1'b1, 2'b10, 16'h0300, 16'h1111, 1'b1, 16'h0000,
                     1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 16'h0300, 16'h1111, 1'b1};
        vecs[13] = '{1'b0, 16'h0000, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0, 16'h0000,
                     1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0};

        do_reset();
        for (int k = 0; k < 14; k++) apply_vec(k, vecs[k]);

        // ---- Tie: i_read and d_read held for 4 transactions ----
        do_reset();
        @(negedge clk);
        i_read = 1; i_address = 16'h0010;
        d_read = 1; d_address = 16'h0020;
        for (int t = 0; t < 4; t++) begin
            logic exp_d;
`ifdef MP3_ARB_ROUND_ROBIN_EN
            exp_d = (t % 2 == 0);
`else
            exp_d = 1'b1;
`endif
            mem_resp = 0;
            #1;
            check($sformatf("tie%0d_idle_busy", t), {15'd0, busy}, 16'd0);
            @(negedge clk);
            mem_resp = 1; mem_rdata = 16'h0A00 + 16'(t);
            #1;
            check($sformatf("tie%0d_d_resp", t), {15'd0, d_resp}, {15'd0, exp_d});
            check($sformatf("tie%0d_i_resp", t), {15'd0, i_resp}, {15'd0, ~exp_d});
            check($sformatf("tie%0d_addr", t), mem_address, exp_d ? 16'h0020 : 16'h0010);
            $display("tie %0d: d_resp=%0b i_resp=%0b addr=%04h", t, d_resp, i_resp, mem_address);
            @(negedge clk);
        end
        drive_idle();

        // ---- Input stability: d_address changes mid-service ----
        @(negedge clk);
        d_read = 1; d_address = 16'h0200;
        @(negedge clk);
        d_address = 16'h0300;
        for (int c = 0; c < 3; c++) begin
            mem_resp = (c == 2);
            mem_rdata = 16'hC0DE;
            #1;
            check($sformatf("stab%0d_addr", c), mem_address, 16'h0200);
            check($sformatf("stab%0d_d_resp", c), {15'd0, d_resp}, {15'd0, (c == 2)});
            $display("stab %0d: addr=%04h d_resp=%0b", c, mem_address, d_resp);
            @(negedge clk);
        end
        drive_idle();

        // ---- Reset mid-transaction: SERVE_D with memory stalling ----
        @(negedge clk);
        d_write = 1; d_address = 16'h0400; d_wdata = 16'h4444; d_wmask = 2'b11;
        @(negedge clk);
        #1;
        check("mrst_pre_write", {15'd0, mem_write}, 16'd1);
        rst_n = 0;
        mem_resp = 1;
        #1;
        check("mrst_write", {15'd0, mem_write}, 16'd0);
        check("mrst_d_resp", {15'd0, d_resp}, 16'd0);
        check("mrst_busy", {15'd0, busy}, 16'd0);
        $display("mid-reset: write=%0b d_resp=%0b busy=%0b", mem_write, d_resp, busy);
        @(negedge clk);
        drive_idle();
        rst_n = 1;
        @(negedge clk);
        #1;
        check("mrst_after_busy", {15'd0, busy}, 16'd0);
        check("mrst_after_d_resp", {15'd0, d_resp}, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mp3_mem_arbiter.md
# mp3_mem_arbiter

Two-to-one memory arbiter for the mp3 core. It shares a single-ported memory between the instruction-fetch port (read-only) and the data port (read/write with byte mask). It sits between the core's two memory ports and the memory model or cache. The response protocol on every side is the core's existing level-request / single-cycle-resp handshake.

## Interface
- ADDR_W, 16, address width on all ports
- DATA_W, 16, data width on all ports
- MASK_W, DATA_W/8, byte-mask width on data and memory ports

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- i_read  in  1  instruction read request, held until i_resp
- i_address  in  ADDR_W  instruction address
- i_resp  out  1  one-cycle instruction completion
- i_rdata  out  DATA_W  instruction data, valid when i_resp
- d_read  in  1  data read request, held until d_resp
- d_write  in  1  data write request, held until d_resp
- d_wmask  in  MASK_W  byte enables for d_write
- d_address  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_resp  out  1  one-cycle data completion
- d_rdata  out  DATA_W  read data, valid when d_resp on a read
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_wmask  out  MASK_W  memory byte enables
- mem_address  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_resp  in  1  memory completion
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, SERVE_I, SERVE_D.
- **IDLE:** all mem_* strobes are 0. On a rising edge with a pending request, the block captures the winner's address, wdata, wmask and op into registers and moves to SERVE_I or SERVE_D.
- **Winner selection:** fixed priority, data over instruction. Round-robin is available under the macro in Configuration.
- **SERVE_x:** mem_read or mem_write is driven from the captured registers, never from the live requester inputs.
  - mem_wmask is the captured mask on writes and all-zero on reads.
  - mem_address and mem_wdata hold the captured values for the whole state.
- **Completion:** while mem_resp=1 in SERVE_x, the block drives the matching x_resp=1 combinationally in the same cycle. x_rdata = mem_rdata. At that edge the FSM returns to IDLE.
  - The other port's resp stays 0.
  - i_rdata and d_rdata pass mem_rdata through at all times; they are meaningful only with resp.
- **Requester drop:** a requester must drop its request in the cycle after its resp, or present a new one. A request still high in IDLE is served as a new request.
- **Illegal d_read and d_write together:** the write is performed; d_resp returns once.
- **Requester changes inputs mid-service:** the captured values are used; the change has no effect until the next grant.
- **mem_resp while IDLE:** ignored; no resp is generated.

## Timing
- **Reset values:**
  - Outputs: mem_read, mem_write, i_resp, d_resp and busy are 0; mem_wmask, mem_address and mem_wdata are 0.
  - State: FSM in IDLE; last-grant register = instruction.
- **Reset mid-operation:** strobes drop asynchronously with rst_n. The in-flight transaction is abandoned and no resp is issued.
- **Request to memory:** 1 cycle. A request sampled at edge N gives mem strobe high from edge N until completion.
- **Memory resp to requester resp:** 0 cycles (combinational).
- **Back-to-back service:** minimum 1 IDLE cycle between transactions. With zero-wait memory (mem_resp in the first SERVE cycle), each transaction occupies 2 cycles.
- **Strobe stability:** mem_read and mem_write never both high, and never change while in SERVE_x before mem_resp.

## Configuration
- Macro: MP3_ARB_ROUND_ROBIN_EN.
- **Defined:**
  - A 1-bit last-grant register updates at each grant.
  - On simultaneous i and d requests in IDLE, the port not granted last wins.
  - A lone request is always granted.
- **Undefined:**
  - Data always wins ties; the last-grant register is absent.
  - Instruction fetch can starve under continuous data traffic; this is accepted.

## Test plan
- **Reset mid-transaction:** assert rst_n=0 during SERVE_D with memory delaying resp → strobes 0 immediately, no d_resp, FSM in IDLE after release.
- **Single fetch:** i_read at 0x0040, memory returns 0x1234 after 3 cycles → mem_read high 3 cycles at address 0x0040, i_resp 1 cycle with i_rdata=0x1234, d_resp stays 0.
- **Masked write:** d_write to 0x0100, wdata 0xBEEF, wmask 2'b01 → mem_write with mem_wmask=2'b01 and mem_wdata=0xBEEF; d_resp with the memory's resp; next cycle busy=0.
- **Tie, fixed priority:** i_read and d_read both held continuously for 4 transactions → all 4 served to data; no i_resp. Macro defined: grants alternate D, I, D, I.
- **Input stability:** d_address changed from 0x0200 to 0x0300 during SERVE_D → mem_address stays 0x0200 until mem_resp.
- **Spurious memory resp:** mem_resp pulsed while IDLE → no i_resp or d_resp; state unchanged.
